// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin lock arbiter: FSM encodings,
// hold counter width and a constant clog2 helper.
package arb_pkg;

    // FSM encodings, kept as plain constants so older code can match on them.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Width of the saturating hold counter (MAX_HOLD is at most 255).
    localparam int HOLD_CNT_W = 8;

    // Ceiling log2 for elaboration-time width calculations.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_lock_arbiter_if.sv
// Requester/arbiter bundle. Requesters (master) drive level requests; the
// arbiter (slave) returns a registered one-hot grant plus its decoded forms.
//
// Handshake: req[i] is a level held by requester i until it is granted and has
// finished; gnt[i] is registered and appears one cycle after req is sampled.
// While gnt[i] is high requester i owns the resource; dropping req[i] releases
// it. Requesters must not withdraw req before being granted.
interface rr_lock_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_valid;
    logic [ID_W-1:0]    gnt_id;
    logic               preempt;

    modport master (
        output req,
        input  gnt,
        input  gnt_valid,
        input  gnt_id,
        input  preempt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_valid,
        output gnt_id,
        output preempt
    );
endinterface

// File: rtl/rr_lock_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: returns the first set bit of
// req_i searching upward from ptr_i and wrapping modulo NUM_REQ.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] win_o,
    output logic [ID_W-1:0]    win_id_o,
    output logic               any_o
);

    // One extra bit so ptr + offset can exceed NUM_REQ-1 before wrapping.
    logic [ID_W:0] idx;

    // Scan NUM_REQ positions starting at ptr_i; the first hit wins.
    always_comb begin
        win_o    = '0;
        win_id_o = '0;
        any_o    = 1'b0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr_i} + (ID_W + 1)'(k);
            if (idx >= (ID_W + 1)'(NUM_REQ)) begin
                idx = idx - (ID_W + 1)'(NUM_REQ);
            end
            if (!any_o && req_i[idx[ID_W-1:0]]) begin
                any_o                 = 1'b1;
                win_o[idx[ID_W-1:0]]  = 1'b1;
                win_id_o              = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// N-way round-robin arbiter with grant locking and bounded hold time.
// The owner keeps the grant while it requests, up to MAX_HOLD cycles when
// someone else is waiting; then it is preempted in favour of the next
// round-robin candidate. Grant, id, valid and preempt are all registered.
module rr_lock_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    rr_lock_arbiter_if.slave      bus,
    output logic [0:0]            dbg_state_o,
    output logic [ID_W-1:0]       dbg_ptr_o,
    output logic [HOLD_CNT_W-1:0] dbg_hold_cnt_o
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LIMIT = HOLD_CNT_W'(MAX_HOLD);

    logic [0:0]            state_q,    state_d;
    logic [ID_W-1:0]       ptr_q,      ptr_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0]    gnt_q,      gnt_d;
    logic [ID_W-1:0]       gnt_id_q,   gnt_id_d;
    logic                  gnt_valid_q;
    logic                  preempt_q,  preempt_d;

    logic                  owner_req;
    logic [NUM_REQ-1:0]    others_req;

    logic [NUM_REQ-1:0]    all_win;
    logic [ID_W-1:0]       all_id;
    logic                  all_any;
    logic [NUM_REQ-1:0]    msk_win;
    logic [ID_W-1:0]       msk_id;
    logic                  msk_any;

    // Round-robin pointer moves to the slot just after the winner.
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
        if (id == ID_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

    assign owner_req  = |(bus.req & gnt_q);
    assign others_req = bus.req & ~gnt_q;

    // Plain pick, used from IDLE and on owner release.
    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick_all (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .win_o    (all_win),
        .win_id_o (all_id),
        .any_o    (all_any)
    );

    // Owner-masked pick, used for hold-timeout preemption.
    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick_masked (
        .req_i    (others_req),
        .ptr_i    (ptr_q),
        .win_o    (msk_win),
        .win_id_o (msk_id),
        .any_o    (msk_any)
    );

    // Next-state logic: grant selection, locking and preemption.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        preempt_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (all_any) begin
                    state_d    = ST_GRANT;
                    gnt_d      = all_win;
                    gnt_id_d   = all_id;
                    hold_cnt_d = HOLD_CNT_W'(1);
                    ptr_d      = next_ptr(all_id);
                end else begin
                    gnt_d      = '0;
                    gnt_id_d   = '0;
                    hold_cnt_d = '0;
                end
            end

            ST_GRANT: begin
                if (!owner_req) begin
                    if (all_any) begin
                        // Hand over directly; no idle bubble.
                        gnt_d      = all_win;
                        gnt_id_d   = all_id;
                        hold_cnt_d = HOLD_CNT_W'(1);
                        ptr_d      = next_ptr(all_id);
                    end else begin
                        state_d    = ST_IDLE;
                        gnt_d      = '0;
                        gnt_id_d   = '0;
                        hold_cnt_d = '0;
                    end
                end else if (hold_cnt_q < HOLD_LIMIT) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end else if (msk_any) begin
                    // Owner has used its budget and someone is waiting.
                    gnt_d      = msk_win;
                    gnt_id_d   = msk_id;
                    preempt_d  = 1'b1;
                    hold_cnt_d = HOLD_CNT_W'(1);
                    ptr_d      = next_ptr(msk_id);
                end
                // Otherwise keep the owner with the counter saturated.
            end

            default: begin
                state_d    = ST_IDLE;
                gnt_d      = '0;
                gnt_id_d   = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // State registers with synchronous, active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= |gnt_d;
            preempt_q   <= preempt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.preempt   = preempt_q;

    assign dbg_state_o    = state_q;
    assign dbg_ptr_o      = ptr_q;
    assign dbg_hold_cnt_o = hold_cnt_q;

endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- N-way round-robin arbiter for a shared single-owner resource (bus, memory port, datapath).
- Extends the team's fixed-priority two-requester grant scheme with three additions: fair rotation, grant locking while the owner keeps requesting, and a bounded hold time with forced preemption.
- Sits between requester clients and the shared resource's select mux; the registered one-hot grant drives the mux directly.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive grant cycles while others wait (1..255).
- ID_W, 2, width of gnt_id; must equal clog2(NUM_REQ).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level; bit i = requester i.
- gnt  output  NUM_REQ  registered one-hot grant; all-zero when idle.
- gnt_valid  output  1  OR of gnt, registered.
- gnt_id  output  ID_W  binary index of current owner; 0 when idle.
- preempt  output  1  one-cycle pulse, coincident with the first cycle of a grant produced by hold-timeout preemption.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset values: gnt=0, gnt_valid=0, gnt_id=0, preempt=0, state=IDLE, rr pointer ptr=0, hold_cnt=0. Reset overrides all other activity, including mid-grant: outputs are zero from the edge where reset is sampled.
- Internal state: FSM {IDLE, GRANT}; ptr (ID_W bits); hold_cnt (8 bits, saturating).
- Pick function: the first set bit of the candidate vector, searched from index ptr upward, wrapping modulo NUM_REQ.
- Latency: 1 cycle from req sampled to gnt asserted. There is no combinational req->gnt path.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise: grant pick(req), go to GRANT, hold_cnt=1, ptr=winner+1 mod NUM_REQ.
- GRANT, owner o:
  - req[o]=0 and another req set: switch directly to pick(req) on the next edge. There is no idle bubble. hold_cnt=1, ptr updated.
  - req[o]=0 and no req set: go to IDLE; gnt=0 on the next edge.
  - req[o]=1, hold_cnt<MAX_HOLD: keep o, hold_cnt+1.
  - req[o]=1, hold_cnt==MAX_HOLD, another req set: preempt. Grant pick(req with bit o masked), preempt=1 for one cycle, hold_cnt=1, ptr updated.
  - req[o]=1, hold_cnt==MAX_HOLD, no other req: keep o; hold_cnt stays at MAX_HOLD. Preemption fires on the first cycle another request appears.
- A request rising in the same cycle as a release or timeout participates in that cycle's pick.
- ptr wraps from NUM_REQ-1 to 0.
- Invariant: gnt is always one-hot or zero.
- Requesters must not drop req without being granted; the arbiter does not queue requests.
- gnt_id and gnt_valid always agree with gnt in the same cycle.

Decomposition:
- Shared package arb_pkg:
  - FSM state encodings (IDLE=1'b0, GRANT=1'b1).
  - clog2 constant function.
  - HOLD_CNT_W=8.
- Sub-module rr_pick: purely combinational masked round-robin priority encoder.
  - Inputs: req vector, ptr.
  - Outputs: one-hot winner, binary winner id, any.
  - Instantiated twice: plain pick and owner-masked pick.

Test Plan (NUM_REQ=4, MAX_HOLD=4):
- Reset then req=4'b0101 -> one cycle later gnt=4'b0001, gnt_id=0. Drop req[0] -> next cycle gnt=4'b0100, gnt_id=2, with no idle cycle.
- req=4'b1111 held, each owner drops after 1 cycle of grant -> grant order 0,1,2,3,0. ptr wraps 3->0.
- req[1] held continuously, req[3] raised at cycle 2 of grant -> owner 1 holds exactly 4 cycles; then gnt=4'b1000 with preempt=1 for exactly one cycle.
- req[2] held alone for 10 cycles -> gnt=4'b0100 throughout, preempt never asserts. Raise req[0] -> next edge gnt=4'b0001, preempt=1.
- Owner 1 releases in the same cycle req[0] and req[3] rise (ptr=2) -> gnt=4'b1000 next cycle, then 0 after 3 releases.
- reset asserted mid-grant (gnt=4'b0010) -> next edge gnt=0, gnt_valid=0, gnt_id=0, preempt=0. After reset, req=4'b1010 -> gnt=4'b0010 because ptr restarts at 0.
